// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolution and a one-cycle fetch redirect.
// Latency: one cycle from EX inputs to MEM outputs; redirect is registered.
// Backpressure: i_stall holds all state; i_flush inserts a bubble and wins over stall.
// Optional feature macro: EX_BRANCH_STATS_EN adds o_branch_cnt / o_taken_cnt counters.
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [3:0]        i_alu_flags,
  input  logic              i_is_branch,
  input  logic              i_is_jump,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_target,
  input  logic [XLEN-1:0]   i_pc_plus4,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_reg_we,
  input  logic              i_mem_we,
  input  logic              i_mem_re,
  input  logic [XLEN-1:0]   i_store_data,
  input  logic              i_stall,
  input  logic              i_flush,
`ifdef EX_BRANCH_STATS_EN
  output logic [31:0]       o_branch_cnt,
  output logic [31:0]       o_taken_cnt,
`endif
  output logic              o_valid,
  output logic [XLEN-1:0]   o_alu_result,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_reg_we,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [XLEN-1:0]   o_store_data,
  output logic              o_redirect,
  output logic [XLEN-1:0]   o_redirect_pc
);

  logic              flag_z, flag_n, flag_c, flag_v;
  logic              cond_d;
  logic              taken_d;
  logic              accept_d;
  logic              reg_we_d;
  logic [XLEN-1:0]   alu_result_d;
  logic [XLEN-1:0]   redirect_pc_d;

  // Set for the single cycle after a taken redirect: the EX instruction then is wrong-path.
  logic              squash_q;

  assign flag_z = i_alu_flags[0];
  assign flag_n = i_alu_flags[1];
  assign flag_c = i_alu_flags[2];
  assign flag_v = i_alu_flags[3];

  // Branch condition from the subtract flags; reserved funct3 codes resolve not-taken.
  always_comb begin
    cond_d = 1'b0;
    case (i_funct3)
      3'b000:  cond_d = flag_z;
      3'b001:  cond_d = ~flag_z;
      3'b100:  cond_d = flag_n ^ flag_v;
      3'b101:  cond_d = ~(flag_n ^ flag_v);
      3'b110:  cond_d = flag_c;
      3'b111:  cond_d = ~flag_c;
      default: cond_d = 1'b0;
    endcase
  end

  assign taken_d       = i_is_jump | (i_is_branch & cond_d);
  assign accept_d      = i_valid & ~squash_q & ~i_stall & ~i_flush;
  // Branches and writes to x0 never update the register file.
  assign reg_we_d      = i_reg_we & ~i_is_branch & (i_rd != '0);
  // Jumps write the link address instead of the ALU output.
  assign alu_result_d  = i_is_jump ? i_pc_plus4 : i_alu_result;
  assign redirect_pc_d = {i_target[XLEN-1:1], 1'b0};

  // Pipeline register: reset, then flush, stall, squash, accept, bubble in priority order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_alu_result  <= '0;
      o_rd          <= '0;
      o_reg_we      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_re      <= 1'b0;
      o_store_data  <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      squash_q      <= 1'b0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_reg_we   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_re   <= 1'b0;
      o_redirect <= 1'b0;
      squash_q   <= 1'b0;
    end else if (i_stall) begin
      // Everything holds except the redirect pulse, which must never repeat.
      o_redirect <= 1'b0;
    end else if (squash_q) begin
      o_valid    <= 1'b0;
      o_reg_we   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_re   <= 1'b0;
      o_redirect <= 1'b0;
      squash_q   <= 1'b0;
    end else if (i_valid) begin
      o_valid      <= 1'b1;
      o_alu_result <= alu_result_d;
      o_rd         <= i_rd;
      o_reg_we     <= reg_we_d;
      o_mem_we     <= i_mem_we;
      o_mem_re     <= i_mem_re;
      o_store_data <= i_store_data;
      o_redirect   <= taken_d;
      squash_q     <= taken_d;
      if (taken_d) begin
        o_redirect_pc <= redirect_pc_d;
      end
    end else begin
      o_valid    <= 1'b0;
      o_reg_we   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_re   <= 1'b0;
      o_redirect <= 1'b0;
    end
  end

`ifdef EX_BRANCH_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  // Count only committed-path (accepted) branches and taken control transfers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (accept_d) begin
      branch_cnt_q <= branch_cnt_q + {31'd0, i_is_branch};
      taken_cnt_q  <= taken_cnt_q + {31'd0, taken_d};
    end
  end

  assign o_branch_cnt = branch_cnt_q;
  assign o_taken_cnt  = taken_cnt_q;
`else
  // Accept only feeds the statistics counters.
  logic unused_accept;
  assign unused_accept = accept_d;
`endif

endmodule
